// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC select and the IF/ID pipeline register.
// Redirects squash the wrong-path fetch with a bubble; stalls freeze the whole stage.
module fetch_stage #(
    parameter int unsigned                DBITS          = 32,
    parameter int unsigned                INST_BIT_WIDTH = 32,
    parameter int unsigned                IMEM_ADDR_BITS = 11,
    parameter logic [DBITS-1:0]           START_PC       = 32'h0000_0040,
    parameter logic [INST_BIT_WIDTH-1:0]  BUBBLE_INST    = 32'hF000_0000
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [IMEM_ADDR_BITS-1:0] imemAddr,
    input  logic [INST_BIT_WIDTH-1:0] imemData,
    input  logic                      stall,
    input  logic [1:0]                pcSel,
    input  logic [DBITS-1:0]          brTarget,
    input  logic [DBITS-1:0]          jmpTarget,
    output logic [DBITS-1:0]          pc,
    output logic [INST_BIT_WIDTH-1:0] instOut,
    output logic [DBITS-1:0]          pcPlus4Out,
    output logic                      validOut,
    output logic [31:0]               fetchCount
);

    localparam logic [1:0] SEL_BRANCH = 2'b01;
    localparam logic [1:0] SEL_JAL    = 2'b10;

    logic [DBITS-1:0]          pc_plus4;
    logic [DBITS-1:0]          pc_next;
    logic [INST_BIT_WIDTH-1:0] inst_next;
    logic [DBITS-1:0]          pc_plus4_next;
    logic                      valid_next;
    logic [31:0]               count_next;

    assign pc_plus4 = pc + DBITS'(4);
    assign imemAddr = pc[IMEM_ADDR_BITS+1:2];

    // Next-state select: redirect beats stall, stall beats sequential.
    always_comb begin
        pc_next       = pc;
        inst_next     = instOut;
        pc_plus4_next = pcPlus4Out;
        valid_next    = validOut;
        count_next    = fetchCount;
        case (pcSel)
            SEL_BRANCH, SEL_JAL: begin
                pc_next       = (pcSel == SEL_BRANCH) ? {brTarget[DBITS-1:2], 2'b00}
                                                      : {jmpTarget[DBITS-1:2], 2'b00};
                inst_next     = BUBBLE_INST;
                pc_plus4_next = '0;
                valid_next    = 1'b0;
            end
            default: begin
                if (!stall) begin
                    pc_next       = pc_plus4;
                    inst_next     = imemData;
                    pc_plus4_next = pc_plus4;
                    valid_next    = 1'b1;
                    count_next    = fetchCount + 32'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc         <= START_PC;
            instOut    <= BUBBLE_INST;
            pcPlus4Out <= '0;
            validOut   <= 1'b0;
            fetchCount <= '0;
        end else begin
            pc         <= pc_next;
            instOut    <= inst_next;
            pcPlus4Out <= pc_plus4_next;
            validOut   <= valid_next;
            fetchCount <= count_next;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, sequential fetch, stall, redirects, wrap, async reset.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic [10:0] imemAddr;
    logic [31:0] imemData;
    logic        stall;
    logic [1:0]  pcSel;
    logic [31:0] brTarget;
    logic [31:0] jmpTarget;
    logic [31:0] pc;
    logic [31:0] instOut;
    logic [31:0] pcPlus4Out;
    logic        validOut;
    logic [31:0] fetchCount;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] BUBBLE = 32'hF000_0000;

    fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .imemAddr   (imemAddr),
        .imemData   (imemData),
        .stall      (stall),
        .pcSel      (pcSel),
        .brTarget   (brTarget),
        .jmpTarget  (jmpTarget),
        .pc         (pc),
        .instOut    (instOut),
        .pcPlus4Out (pcPlus4Out),
        .validOut   (validOut),
        .fetchCount (fetchCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: word 16 is the known first instruction, others tag their address.
    function automatic logic [31:0] mem(input logic [10:0] a);
        if (a == 11'd16) return 32'h0012_3000;
        return 32'hA500_0000 | 32'(a);
    endfunction

    assign imemData = mem(imemAddr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; pcSel = 2'b00; brTarget = '0; jmpTarget = '0;
        tick(); tick();
        n_checks++; if (pc !== 32'h40) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h40); end
        n_checks++; if (instOut !== BUBBLE) begin n_fail++; $display("FAIL reset_inst: got %h expected %h", instOut, BUBBLE); end
        n_checks++; if (pcPlus4Out !== 32'h0) begin n_fail++; $display("FAIL reset_pcplus4: got %h expected %h", pcPlus4Out, 32'h0); end
        n_checks++; if (validOut !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", validOut); end
        n_checks++; if (fetchCount !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", fetchCount); end
        reset = 1'b0;
        n_checks++; if (imemAddr !== 11'd16) begin n_fail++; $display("FAIL reset_imemaddr: got %0d expected 16", imemAddr); end
    endtask

    task automatic test_first_fetch();
        tick();
        n_checks++; if (pc !== 32'h44) begin n_fail++; $display("FAIL first_pc: got %h expected %h", pc, 32'h44); end
        n_checks++; if (instOut !== 32'h0012_3000) begin n_fail++; $display("FAIL first_inst: got %h expected %h", instOut, 32'h0012_3000); end
        n_checks++; if (pcPlus4Out !== 32'h44) begin n_fail++; $display("FAIL first_pcplus4: got %h expected %h", pcPlus4Out, 32'h44); end
        n_checks++; if (validOut !== 1'b1) begin n_fail++; $display("FAIL first_valid: got %b expected 1", validOut); end
        n_checks++; if (fetchCount !== 32'd1) begin n_fail++; $display("FAIL first_count: got %0d expected 1", fetchCount); end
    endtask

    task automatic test_stall();
        tick(); tick(); tick();
        n_checks++; if (pc !== 32'h50) begin n_fail++; $display("FAIL seq_pc: got %h expected %h", pc, 32'h50); end
        n_checks++; if (instOut !== 32'hA500_0013) begin n_fail++; $display("FAIL seq_inst: got %h expected %h", instOut, 32'hA500_0013); end
        n_checks++; if (fetchCount !== 32'd4) begin n_fail++; $display("FAIL seq_count: got %0d expected 4", fetchCount); end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (pc !== 32'h50) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h expected %h", i, pc, 32'h50); end
            n_checks++; if (imemAddr !== 11'd20) begin n_fail++; $display("FAIL stall_imemaddr[%0d]: got %0d expected 20", i, imemAddr); end
            n_checks++; if (instOut !== 32'hA500_0013) begin n_fail++; $display("FAIL stall_inst[%0d]: got %h expected %h", i, instOut, 32'hA500_0013); end
            n_checks++; if (pcPlus4Out !== 32'h50) begin n_fail++; $display("FAIL stall_pcplus4[%0d]: got %h expected %h", i, pcPlus4Out, 32'h50); end
            n_checks++; if (fetchCount !== 32'd4) begin n_fail++; $display("FAIL stall_count[%0d]: got %0d expected 4", i, fetchCount); end
        end
        stall = 1'b0;
        tick();
        n_checks++; if (pc !== 32'h54) begin n_fail++; $display("FAIL resume_pc: got %h expected %h", pc, 32'h54); end
        n_checks++; if (instOut !== 32'hA500_0014) begin n_fail++; $display("FAIL resume_inst: got %h expected %h", instOut, 32'hA500_0014); end
        n_checks++; if (fetchCount !== 32'd5) begin n_fail++; $display("FAIL resume_count: got %0d expected 5", fetchCount); end
    endtask

    task automatic test_branch();
        reset = 1'b1; #1; reset = 1'b0;
        tick(); tick();
        n_checks++; if (pc !== 32'h48) begin n_fail++; $display("FAIL br_setup_pc: got %h expected %h", pc, 32'h48); end
        pcSel = 2'b01; brTarget = 32'h0000_0102;
        tick();
        n_checks++; if (pc !== 32'h100) begin n_fail++; $display("FAIL br_pc: got %h expected %h", pc, 32'h100); end
        n_checks++; if (instOut !== BUBBLE) begin n_fail++; $display("FAIL br_inst: got %h expected %h", instOut, BUBBLE); end
        n_checks++; if (validOut !== 1'b0) begin n_fail++; $display("FAIL br_valid: got %b expected 0", validOut); end
        n_checks++; if (pcPlus4Out !== 32'h0) begin n_fail++; $display("FAIL br_pcplus4: got %h expected 0", pcPlus4Out); end
        n_checks++; if (fetchCount !== 32'd2) begin n_fail++; $display("FAIL br_count: got %0d expected 2", fetchCount); end
        pcSel = 2'b00;
        tick();
        n_checks++; if (pc !== 32'h104) begin n_fail++; $display("FAIL br_next_pc: got %h expected %h", pc, 32'h104); end
        n_checks++; if (instOut !== 32'hA500_0040) begin n_fail++; $display("FAIL br_next_inst: got %h expected %h", instOut, 32'hA500_0040); end
        n_checks++; if (validOut !== 1'b1) begin n_fail++; $display("FAIL br_next_valid: got %b expected 1", validOut); end
        n_checks++; if (pcPlus4Out !== 32'h104) begin n_fail++; $display("FAIL br_next_pcplus4: got %h expected %h", pcPlus4Out, 32'h104); end
        n_checks++; if (fetchCount !== 32'd3) begin n_fail++; $display("FAIL br_next_count: got %0d expected 3", fetchCount); end
    endtask

    task automatic test_back_to_back();
        pcSel = 2'b10; jmpTarget = 32'h200; stall = 1'b1;
        tick();
        n_checks++; if (pc !== 32'h200) begin n_fail++; $display("FAIL jal_stall_pc: got %h expected %h", pc, 32'h200); end
        n_checks++; if (validOut !== 1'b0) begin n_fail++; $display("FAIL jal_stall_valid: got %b expected 0", validOut); end
        n_checks++; if (instOut !== BUBBLE) begin n_fail++; $display("FAIL jal_stall_inst: got %h expected %h", instOut, BUBBLE); end
        pcSel = 2'b01; brTarget = 32'h303; stall = 1'b0;
        tick();
        n_checks++; if (pc !== 32'h300) begin n_fail++; $display("FAIL b2b_pc: got %h expected %h", pc, 32'h300); end
        n_checks++; if (validOut !== 1'b0) begin n_fail++; $display("FAIL b2b_valid: got %b expected 0", validOut); end
        n_checks++; if (fetchCount !== 32'd3) begin n_fail++; $display("FAIL b2b_count: got %0d expected 3", fetchCount); end
    endtask

    task automatic test_wrap();
        pcSel = 2'b10; jmpTarget = 32'hFFFF_FFFE;
        tick();
        n_checks++; if (pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_setup_pc: got %h expected %h", pc, 32'hFFFF_FFFC); end
        pcSel = 2'b11;
        tick();
        n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pc: got %h expected 0", pc); end
        n_checks++; if (pcPlus4Out !== 32'h0) begin n_fail++; $display("FAIL wrap_pcplus4: got %h expected 0", pcPlus4Out); end
        n_checks++; if (validOut !== 1'b1) begin n_fail++; $display("FAIL wrap_valid: got %b expected 1", validOut); end
        n_checks++; if (instOut !== 32'hA500_07FF) begin n_fail++; $display("FAIL wrap_inst: got %h expected %h", instOut, 32'hA500_07FF); end
        n_checks++; if (fetchCount !== 32'd4) begin n_fail++; $display("FAIL wrap_count: got %0d expected 4", fetchCount); end
    endtask

    task automatic test_async_reset();
        pcSel = 2'b00;
        tick(); tick(); tick();
        stall = 1'b1;
        tick();
        n_checks++; if (fetchCount !== 32'd7) begin n_fail++; $display("FAIL pre_areset_count: got %0d expected 7", fetchCount); end
        n_checks++; if (pc !== 32'hC) begin n_fail++; $display("FAIL pre_areset_pc: got %h expected %h", pc, 32'hC); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (pc !== 32'h40) begin n_fail++; $display("FAIL areset_pc: got %h expected %h", pc, 32'h40); end
        n_checks++; if (validOut !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %b expected 0", validOut); end
        n_checks++; if (fetchCount !== 32'd0) begin n_fail++; $display("FAIL areset_count: got %0d expected 0", fetchCount); end
        n_checks++; if (instOut !== BUBBLE) begin n_fail++; $display("FAIL areset_inst: got %h expected %h", instOut, BUBBLE); end
        n_checks++; if (pcPlus4Out !== 32'h0) begin n_fail++; $display("FAIL areset_pcplus4: got %h expected 0", pcPlus4Out); end
        tick();
        reset = 1'b0; stall = 1'b0;
        tick();
        n_checks++; if (pc !== 32'h44) begin n_fail++; $display("FAIL post_areset_pc: got %h expected %h", pc, 32'h44); end
        n_checks++; if (fetchCount !== 32'd1) begin n_fail++; $display("FAIL post_areset_count: got %0d expected 1", fetchCount); end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_stall();
        test_branch();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register, directly upstream of the decode controller.
- Holds the PC and drives the instruction-memory word address.
- Applies the decode-stage next-PC select (pcSel 00 = PC+4, 01 = branch, 10 = JAL) and registers the fetched instruction plus PC+4 for decode.
- Handles hazard stalls, redirect flushes and a retired-fetch counter.

Parameters:
- DBITS, 32, PC and data width.
- INST_BIT_WIDTH, 32, instruction width.
- IMEM_ADDR_BITS, 11, instruction-memory word-address width.
- START_PC, 32'h0000_0040, PC value after reset.
- BUBBLE_INST, 32'hF000_0000, instruction inserted on flush/reset; opcode 4'b1111 decodes to no register write, no memory access, pcSel 00.

Ports:
- clk  input  1  Single clock, rising edge.
- reset  input  1  Asynchronous, active-high reset.
- imemAddr  output  IMEM_ADDR_BITS  Word address to instruction memory, equal to pc[IMEM_ADDR_BITS+1:2]. Combinational from the PC register.
- imemData  input  INST_BIT_WIDTH  Instruction word returned combinationally for imemAddr.
- stall  input  1  Hazard hold. Freezes PC and the IF/ID register.
- pcSel  input  2  From decode: 00 sequential, 01 branch taken, 10 JAL, 11 treated as 00.
- brTarget  input  DBITS  Branch target (decode PC+4 + imm*4, computed downstream).
- jmpTarget  input  DBITS  JAL target (register + imm<<2, computed downstream).
- pc  output  DBITS  Current fetch PC (registered).
- instOut  output  INST_BIT_WIDTH  IF/ID instruction to decode.
- pcPlus4Out  output  DBITS  IF/ID PC+4 of instOut.
- validOut  output  1  IF/ID holds a real instruction; 0 means bubble.
- fetchCount  output  32  Number of instructions accepted into IF/ID since reset.

Behaviour:
- Reset (asynchronous, any time, including mid-stall or mid-redirect):
  - pc = START_PC, instOut = BUBBLE_INST, pcPlus4Out = 0, validOut = 0, fetchCount = 0.
- First real instruction appears at instOut on the first rising edge after reset deasserts, i.e. 1-cycle fetch latency.
- Next-state priority each edge (after reset): redirect > stall > sequential.
- Redirect (pcSel == 01 or 10):
  - pc <= target with bits [1:0] forced to 0; 01 uses brTarget, 10 uses jmpTarget.
  - IF/ID loaded with instOut = BUBBLE_INST, validOut = 0, pcPlus4Out = 0; this squashes the wrong-path fetch.
  - fetchCount unchanged.
  - Redirect overrides a simultaneous stall.
- Stall (stall = 1, no redirect):
  - pc, instOut, pcPlus4Out, validOut and fetchCount all hold.
  - imemAddr stays constant.
- Sequential (pcSel 00/11, stall = 0):
  - pc <= pc + 4, wrapping modulo 2^DBITS (32'hFFFF_FFFC -> 0).
  - instOut <= imemData, pcPlus4Out <= pc + 4, validOut <= 1.
  - fetchCount <= fetchCount + 1, wrapping at 2^32.
- pcSel is sampled only on the clock edge; combinational glitches between edges have no effect.
- Decode feeds pcSel back from instOut. While validOut = 0, the bubble decodes to pcSel 00, so a bubble never causes a redirect.
- Back-to-back redirects in consecutive cycles are legal; each one reloads pc and bubbles IF/ID.
- All arithmetic is unsigned DBITS-wide; no exceptions on misaligned targets (low bits silently cleared).

Test Plan:
- Reset, release, imemData = mem[pc>>2] with mem[16] = 32'h0012_3000 -> cycle 1: pc = 0x44, instOut = 32'h0012_3000, pcPlus4Out = 0x44, validOut = 1, fetchCount = 1; imemAddr = 16 before the edge.
- Sequential run of 4 cycles then stall = 1 for 3 cycles -> pc = 0x50 held, instOut/pcPlus4Out/fetchCount (= 4) unchanged during stall; resumes at 0x54 after stall drops.
- pcSel = 01, brTarget = 32'h0000_0102 at pc = 0x48 -> next pc = 0x100, instOut = 32'hF000_0000, validOut = 0, fetchCount unchanged; following cycle fetches 0x100, validOut = 1.
- pcSel = 10 with jmpTarget = 0x200 and stall = 1 simultaneously -> pc = 0x200, bubble inserted (redirect beats stall).
- Force pc to 32'hFFFF_FFFC via jmpTarget, then one sequential cycle -> pc = 0, pcPlus4Out = 0, validOut = 1; pcSel = 11 behaves identically to 00.
- Assert reset asynchronously mid-cycle during a stall with fetchCount = 7 -> outputs immediately at reset values (pc = 0x40, validOut = 0, fetchCount = 0) without waiting for a clock edge.
